// File: rtl/scope_capture.sv
// Capture stage behind adc_driver: paces conversions, keeps a circular sample buffer
// with pre-trigger history, and freezes one DEPTH-sample record for random-access readout.
module scope_capture #(
  parameter int DATA_W   = 10,
  parameter int ADDR_W   = 8,
  parameter int PRE_TRIG = 64,
  parameter int DIV_W    = 16
) (
  input  logic              s_clk_i,
  input  logic              rst_i,
  input  logic              arm_i,
  input  logic [DIV_W-1:0]  sample_div_i,
  input  logic [DATA_W-1:0] trig_level_i,
  input  logic              trig_rising_i,
  input  logic              force_trig_i,
  input  logic              adc_ready_i,
  input  logic [DATA_W-1:0] adc_data_i,
  output logic              start_sample_o,
  output logic              busy_o,
  output logic              done_o,
  input  logic [ADDR_W-1:0] rd_addr_i,
  output logic [DATA_W-1:0] rd_data_o
);

  localparam int DEPTH = 2 ** ADDR_W;
  localparam logic [ADDR_W-1:0] PRE_LAST  = ADDR_W'(PRE_TRIG - 1);
  localparam logic [ADDR_W-1:0] POST_LAST = ADDR_W'(DEPTH - PRE_TRIG - 1);
  localparam bit ONE_POST = (DEPTH - PRE_TRIG) == 1;

  typedef enum logic [2:0] {IDLE, PRE, WAIT, POST, DONE} state_t;

  state_t            r_state, w_stateNext;
  logic [DATA_W-1:0] r_buf [DEPTH];
  logic [ADDR_W-1:0] r_wrPtr, r_cnt, r_base;
  logic [DIV_W-1:0]  r_div;
  logic              r_outstanding, r_prevValid, r_forcePend;
  logic [DATA_W-1:0] r_prev, r_rdData;
  logic [ADDR_W-1:0] w_rdIdx;
  logic              w_busy, w_accept, w_start, w_armLoad, w_levelHit, w_trig, w_finish;

  assign w_busy    = (r_state == PRE) || (r_state == WAIT) || (r_state == POST);
  assign w_accept  = w_busy && adc_ready_i;
  assign w_start   = w_busy && (r_div == '0) && !r_outstanding;
  assign w_armLoad = ((r_state == IDLE) || (r_state == DONE)) && arm_i;
  assign w_rdIdx   = r_base + rd_addr_i;

  assign w_levelHit = r_prevValid && (trig_rising_i ?
                      ((r_prev < trig_level_i) && (adc_data_i >= trig_level_i)) :
                      ((r_prev > trig_level_i) && (adc_data_i <= trig_level_i)));

  always_comb begin
    w_stateNext = r_state;
    w_trig      = 1'b0;
    w_finish    = 1'b0;
    case (r_state)
      IDLE, DONE: if (arm_i) w_stateNext = PRE;
      PRE:        if (w_accept && (r_cnt == PRE_LAST)) w_stateNext = WAIT;
      WAIT: begin
        if (w_accept && (r_forcePend || w_levelHit)) begin
          w_trig = 1'b1;
          if (ONE_POST) begin
            w_stateNext = DONE;
            w_finish    = 1'b1;
          end else begin
            w_stateNext = POST;
          end
        end
      end
      POST: begin
        if (w_accept && (r_cnt == POST_LAST)) begin
          w_stateNext = DONE;
          w_finish    = 1'b1;
        end
      end
      default: w_stateNext = IDLE;
    endcase
  end

  always_ff @(posedge s_clk_i) begin
    if (rst_i) r_state <= IDLE;
    else       r_state <= w_stateNext;
  end

  always_ff @(posedge s_clk_i) begin
    if (rst_i) begin
      r_wrPtr       <= '0;
      r_cnt         <= '0;
      r_base        <= '0;
      r_div         <= '0;
      r_outstanding <= 1'b0;
      r_prevValid   <= 1'b0;
      r_forcePend   <= 1'b0;
      r_prev        <= '0;
      r_rdData      <= '0;
    end else begin
      r_rdData <= r_buf[w_rdIdx];
      if (w_armLoad) begin
        r_wrPtr       <= '0;
        r_cnt         <= '0;
        r_div         <= '0;
        r_outstanding <= 1'b0;
        r_prevValid   <= 1'b0;
        r_forcePend   <= 1'b0;
      end else if (w_busy) begin
        if (w_start) begin
          r_div         <= sample_div_i;
          r_outstanding <= 1'b1;
        end else begin
          if (r_div != '0) r_div <= r_div - 1'b1;
          if (adc_ready_i) r_outstanding <= 1'b0;
        end
        if ((r_state == WAIT) && force_trig_i) r_forcePend <= 1'b1;
        if (w_accept) begin
          r_wrPtr     <= r_wrPtr + 1'b1;
          r_prev      <= adc_data_i;
          r_prevValid <= 1'b1;
          case (r_state)
            PRE:  r_cnt <= (r_cnt == PRE_LAST) ? '0 : r_cnt + 1'b1;
            WAIT: begin
              if (w_trig) begin
                r_cnt       <= ADDR_W'(1);
                r_forcePend <= 1'b0;
              end
            end
            POST:    r_cnt <= r_cnt + 1'b1;
            default: r_cnt <= r_cnt;
          endcase
          // The slot after the final write is the oldest sample of the frozen record.
          if (w_finish) r_base <= r_wrPtr + 1'b1;
        end
      end
    end
  end

  always_ff @(posedge s_clk_i) begin
    if (w_accept && !rst_i) r_buf[r_wrPtr] <= adc_data_i;
  end

  assign start_sample_o = w_start;
  assign busy_o         = w_busy;
  assign done_o         = (r_state == DONE);
  assign rd_data_o      = r_rdData;

endmodule

// File: tb/tb_scope_capture.sv
// Bench for scope_capture: ADC response model, table of capture scenarios with a
// readout scoreboard, and hand-written sequences for arm/reset mid-capture and pacing.
module tb_scope_capture;

  localparam int DATA_W   = 10;
  localparam int ADDR_W   = 4;
  localparam int DEPTH    = 16;
  localparam int PRE_TRIG = 4;
  localparam int DIV_W    = 16;

  logic              clk = 1'b0;
  logic              rst_i = 1'b1;
  logic              arm_i = 1'b0;
  logic [DIV_W-1:0]  sample_div_i = DIV_W'(3);
  logic [DATA_W-1:0] trig_level_i = '0;
  logic              trig_rising_i = 1'b1;
  logic              force_trig_i = 1'b0;
  logic              adc_ready_i;
  logic [DATA_W-1:0] adc_data_i;
  logic              start_sample_o, busy_o, done_o;
  logic [ADDR_W-1:0] rd_addr_i = '0;
  logic [DATA_W-1:0] rd_data_o;

  always #5 clk = ~clk;

  scope_capture #(
    .DATA_W(DATA_W), .ADDR_W(ADDR_W), .PRE_TRIG(PRE_TRIG), .DIV_W(DIV_W)
  ) dut (
    .s_clk_i(clk), .rst_i(rst_i), .arm_i(arm_i), .sample_div_i(sample_div_i),
    .trig_level_i(trig_level_i), .trig_rising_i(trig_rising_i),
    .force_trig_i(force_trig_i), .adc_ready_i(adc_ready_i), .adc_data_i(adc_data_i),
    .start_sample_o(start_sample_o), .busy_o(busy_o), .done_o(done_o),
    .rd_addr_i(rd_addr_i), .rd_data_o(rd_data_o)
  );

  int passCount = 0;
  int checkCount = 0;

  int adcLatency = 8;
  int adcCnt = 0;
  int sampleMode = 0;
  int sampleIdx = 0;
  int fedQ[$];
  int startCount = 0;
  int cycleNum = 0;
  int lastStart = -1;
  int minGap = 1000000;
  int maxGap = 0;
  int gap = 0;
  int overlapErrs = 0;

  typedef struct {
    int mode;
    int level;
    bit rising;
    bit useForce;
    int expLen;
    int exp0;
    int exp4;
    int exp15;
  } capVec_t;

  function automatic int sampleValue(int mode, int k);
    case (mode)
      0:       return 10 * k;
      1:       return (k <= 10) ? 100 - 10 * k : 0;
      default: return 300;
    endcase
  endfunction

  task automatic checkOutput(string name, int actual, int expected);
    checkCount++;
    if (actual == expected) passCount++;
    else $display("[TB] FAIL %s: got %0d, want %0d", name, actual, expected);
  endtask

  // ADC model: answers adcLatency cycles after each start pulse, tracks pacing.
  initial begin
    adc_ready_i = 1'b0;
    adc_data_i  = '0;
    forever begin
      @(negedge clk);
      cycleNum++;
      adc_ready_i = 1'b0;
      if (adcCnt > 0) begin
        adcCnt--;
        if (adcCnt == 0) begin
          adc_data_i = DATA_W'(sampleValue(sampleMode, sampleIdx));
          fedQ.push_back(int'(adc_data_i));
          sampleIdx++;
          adc_ready_i = 1'b1;
        end
      end
      if (start_sample_o) begin
        if (adcCnt > 0 || adc_ready_i) overlapErrs++;
        startCount++;
        if (lastStart >= 0) begin
          gap = cycleNum - lastStart;
          if (gap < minGap) minGap = gap;
          if (gap > maxGap) maxGap = gap;
        end
        lastStart = cycleNum;
        adcCnt = adcLatency;
      end
    end
  end

  task automatic applyStimulus(int mode, int level, bit rising);
    @(negedge clk);
    sampleMode    = mode;
    sampleIdx     = 0;
    fedQ.delete();
    trig_level_i  = DATA_W'(level);
    trig_rising_i = rising;
    lastStart     = -1;
    minGap        = 1000000;
    maxGap        = 0;
    arm_i = 1'b1;
    @(negedge clk);
    arm_i = 1'b0;
    checkOutput("start pulse cycle after arm", int'(start_sample_o), 1);
    checkOutput("busy after arm", int'(busy_o), 1);
    checkOutput("done cleared after arm", int'(done_o), 0);
  endtask

  task automatic waitDone(string name, int budget);
    int n = 0;
    while (!done_o && n < budget) begin
      @(negedge clk);
      n++;
    end
    checkOutput(name, int'(done_o), 1);
  endtask

  task automatic waitSamples(int count, int budget);
    int n = 0;
    while (fedQ.size() < count && n < budget) begin
      @(negedge clk);
      n++;
    end
    checkOutput("sample count reached", int'(fedQ.size() >= count), 1);
  endtask

  task automatic checkAddr(string name, int addr, int expected);
    rd_addr_i = ADDR_W'(addr);
    @(negedge clk);
    checkOutput(name, int'(rd_data_o), expected);
  endtask

  // Expected record is the last DEPTH samples the model delivered.
  task automatic readRecord(string tag);
    int expQ[$];
    int base;
    if (fedQ.size() < DEPTH) begin
      checkOutput({tag, " record length"}, fedQ.size(), DEPTH);
      return;
    end
    base = fedQ.size() - DEPTH;
    for (int i = 0; i < DEPTH; i++) begin
      rd_addr_i = ADDR_W'(i);
      expQ.push_back(fedQ[base + i]);
      @(negedge clk);
      checkOutput($sformatf("%s rd[%0d]", tag, i), int'(rd_data_o), expQ.pop_front());
    end
  endtask

  initial begin
    #1_000_000;
    $display("[TB] FAIL watchdog: simulation did not finish, got timeout, want completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    capVec_t vecs[3];
    int s;
    vecs[0] = '{mode: 0, level: 55, rising: 1'b1, useForce: 1'b0, expLen: 18, exp0: 20,  exp4: 60,  exp15: 170};
    vecs[1] = '{mode: 1, level: 45, rising: 1'b0, useForce: 1'b0, expLen: 18, exp0: 80,  exp4: 40,  exp15: 0};
    vecs[2] = '{mode: 2, level: 55, rising: 1'b1, useForce: 1'b1, expLen: 18, exp0: 300, exp4: 300, exp15: 300};

    repeat (3) @(negedge clk);
    checkOutput("reset busy", int'(busy_o), 0);
    checkOutput("reset done", int'(done_o), 0);
    checkOutput("reset rd_data", int'(rd_data_o), 0);
    checkOutput("reset start", int'(start_sample_o), 0);
    rst_i = 1'b0;
    repeat (50) @(negedge clk);
    checkOutput("idle start pulses", startCount, 0);
    checkOutput("idle busy", int'(busy_o), 0);
    checkOutput("idle done", int'(done_o), 0);

    for (int i = 0; i < 3; i++) begin
      applyStimulus(vecs[i].mode, vecs[i].level, vecs[i].rising);
      if (vecs[i].useForce) begin
        waitSamples(6, 500);
        @(posedge clk);
        @(negedge clk);
        checkOutput("busy before force", int'(busy_o), 1);
        checkOutput("no trigger before force", int'(done_o), 0);
        force_trig_i = 1'b1;
        @(negedge clk);
        force_trig_i = 1'b0;
      end
      waitDone($sformatf("vec%0d done", i), 2000);
      checkOutput($sformatf("vec%0d samples to done", i), fedQ.size(), vecs[i].expLen);
      checkOutput($sformatf("vec%0d min start gap", i), minGap, 9);
      checkOutput($sformatf("vec%0d max start gap", i), maxGap, 9);
      checkAddr($sformatf("vec%0d rd0", i), 0, vecs[i].exp0);
      checkAddr($sformatf("vec%0d rd4 trigger", i), PRE_TRIG, vecs[i].exp4);
      checkAddr($sformatf("vec%0d rd15", i), 15, vecs[i].exp15);
      readRecord($sformatf("vec%0d", i));
    end

    // arm mid-POST must be ignored
    applyStimulus(0, 55, 1'b1);
    waitSamples(10, 500);
    @(negedge clk);
    arm_i = 1'b1;
    @(negedge clk);
    arm_i = 1'b0;
    checkOutput("busy after mid-POST arm", int'(busy_o), 1);
    waitDone("mid-POST arm done", 2000);
    checkOutput("mid-POST arm samples", fedQ.size(), 18);
    checkAddr("mid-POST arm rd4", PRE_TRIG, 60);
    readRecord("midarm");

    // reset mid-POST aborts the capture
    applyStimulus(0, 55, 1'b1);
    waitSamples(10, 500);
    @(negedge clk);
    rst_i = 1'b1;
    @(negedge clk);
    rst_i = 1'b0;
    checkOutput("abort busy", int'(busy_o), 0);
    checkOutput("abort done", int'(done_o), 0);
    checkOutput("abort start", int'(start_sample_o), 0);
    s = startCount;
    repeat (30) @(negedge clk);
    checkOutput("abort no later starts", startCount - s, 0);
    checkOutput("abort stays idle", int'(busy_o), 0);

    // slow ADC: one conversion outstanding at a time
    adcLatency = 20;
    applyStimulus(0, 55, 1'b1);
    waitDone("slow adc done", 3000);
    checkOutput("slow adc min gap >= 21", int'(minGap >= 21), 1);
    checkOutput("slow adc samples", fedQ.size(), 18);
    checkAddr("slow adc rd4", PRE_TRIG, 60);
    checkOutput("start while outstanding", overlapErrs, 0);

    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
